// File: rtl/svm_sched_pkg.sv
// svm_sched_pkg: types and constants shared by the
// scheduler-side blocks (lane states, transaction bundle).
package svm_sched_pkg;

  localparam int OWNER_ID_W = 64;
  localparam int MAX_DEPS   = 1024;

  typedef enum logic [1:0] {
    LANE_IDLE,
    LANE_EXEC,
    LANE_RETIRE
  } lane_state_e;

  typedef struct packed {
    logic [OWNER_ID_W-1:0] owner;
    logic [MAX_DEPS-1:0]   rd;
    logic [MAX_DEPS-1:0]   wr;
  } txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter, one-hot grant plus
// index; pointer moves past the winner on an advance strobe.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;

  // first requester at or after the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // pointer moves to winner+1, wrapping at N
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      if (gnt_idx == IW'(N - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + IW'(1);
    end
  end

  // pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/txn_dispatcher.sv
// txn_dispatcher: parks scheduled txns in lanes, releases deps
// on completion. Stats outputs need TXN_DISPATCHER_STATS_EN.
module txn_dispatcher
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES = MAX_DEPS,
  parameter int NUM_LANES        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [OWNER_ID_W-1:0]         s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]   s_axis_tdata_write_dependencies,
  output logic [NUM_LANES-1:0]          exec_valid,
  output logic [OWNER_ID_W*NUM_LANES-1:0] exec_owner_programID,
  input  logic [NUM_LANES-1:0]          exec_done,
  output logic                          m_axis_rel_tvalid,
  input  logic                          m_axis_rel_tready,
  output logic [OWNER_ID_W-1:0]         m_axis_rel_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]   m_axis_rel_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]   m_axis_rel_write_dependencies,
  output logic [31:0]                   lanes_busy,
  output logic [31:0]                   txns_dispatched,
  output logic [31:0]                   txns_retired
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  lane_state_e st_q  [NUM_LANES];
  lane_state_e st_d  [NUM_LANES];
  txn_t        txn_q [NUM_LANES];
  txn_t        txn_d [NUM_LANES];
  txn_t        rel_q, rel_d;
  logic        rel_vld_q, rel_vld_d;
  txn_t        in_txn;

  logic [NUM_LANES-1:0] idle_v, retire_v, acc_sel, gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 acc, rel_hs, rel_free, adv;

  // per-lane status decode from registered state only
  always_comb begin
    idle_v               = '0;
    retire_v             = '0;
    exec_valid           = '0;
    exec_owner_programID = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idle_v[i]     = (st_q[i] == LANE_IDLE);
      retire_v[i]   = (st_q[i] == LANE_RETIRE);
      exec_valid[i] = (st_q[i] == LANE_EXEC);
      exec_owner_programID[OWNER_ID_W*i +: OWNER_ID_W] =
        txn_q[i].owner;
    end
  end

  assign in_txn.owner = s_axis_tdata_owner_programID;
  assign in_txn.rd    = s_axis_tdata_read_dependencies;
  assign in_txn.wr    = s_axis_tdata_write_dependencies;

  assign s_axis_tready = |idle_v;
  assign acc      = s_axis_tvalid && s_axis_tready;
  assign acc_sel  = idle_v & (~idle_v + NUM_LANES'(1));
  assign rel_hs   = rel_vld_q && m_axis_rel_tready;
  assign rel_free = !rel_vld_q || m_axis_rel_tready;
  assign adv      = rel_free && (|retire_v);

  rr_arbiter #(
    .N (NUM_LANES)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (retire_v),
    .adv     (adv),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // lane FSMs and release register next state
  always_comb begin
    st_d      = st_q;
    txn_d     = txn_q;
    rel_d     = rel_q;
    rel_vld_d = rel_vld_q;
    if (rel_hs)
      rel_vld_d = 1'b0;
    if (adv) begin
      rel_d     = txn_q[gnt_idx];
      rel_vld_d = 1'b1;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      unique case (st_q[i])
        LANE_IDLE: begin
          if (acc && acc_sel[i]) begin
            st_d[i]  = LANE_EXEC;
            txn_d[i] = in_txn;
          end
        end
        LANE_EXEC: begin
          if (exec_done[i])
            st_d[i] = LANE_RETIRE;
        end
        LANE_RETIRE: begin
          if (adv && gnt[i])
            st_d[i] = LANE_IDLE;
        end
        default: st_d[i] = LANE_IDLE;
      endcase
    end
  end

  // lane and release state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        st_q[i]  <= LANE_IDLE;
        txn_q[i] <= '0;
      end
      rel_q     <= '0;
      rel_vld_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      txn_q     <= txn_d;
      rel_q     <= rel_d;
      rel_vld_q <= rel_vld_d;
    end
  end

  assign m_axis_rel_tvalid             = rel_vld_q;
  assign m_axis_rel_owner_programID    = rel_q.owner;
  assign m_axis_rel_read_dependencies  = rel_q.rd;
  assign m_axis_rel_write_dependencies = rel_q.wr;

`ifdef TXN_DISPATCHER_STATS_EN
  logic [31:0] disp_q, disp_d, ret_q, ret_d, busy_q, busy_d;

  // counters wrap; busy tracks the post-edge lane states
  always_comb begin
    disp_d = disp_q + 32'(acc);
    ret_d  = ret_q + 32'(rel_hs);
    busy_d = '0;
    for (int i = 0; i < NUM_LANES; i++)
      busy_d = busy_d + 32'(st_d[i] != LANE_IDLE);
  end

  // statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      ret_q  <= '0;
      busy_q <= '0;
    end else begin
      disp_q <= disp_d;
      ret_q  <= ret_d;
      busy_q <= busy_d;
    end
  end

  assign txns_dispatched = disp_q;
  assign txns_retired    = ret_q;
  assign lanes_busy      = busy_q;
`else
  assign txns_dispatched = 32'd0;
  assign txns_retired    = 32'd0;
  assign lanes_busy      = 32'd0;
`endif

endmodule

// File: tb/tb_txn_dispatcher.sv
// tb_txn_dispatcher: directed stimulus with a release
// scoreboard checked by an independent monitor.
module tb_txn_dispatcher;
  import svm_sched_pkg::*;

  localparam int MD = 1024;
  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [63:0]     s_owner;
  logic [MD-1:0]   s_rd, s_wr;
  logic [NL-1:0]   exec_valid;
  logic [64*NL-1:0] exec_owner;
  logic [NL-1:0]   exec_done;
  logic            rel_tvalid, rel_tready;
  logic [63:0]     rel_owner;
  logic [MD-1:0]   rel_rd, rel_wr;
  logic [31:0]     lanes_busy, txns_dispatched, txns_retired;

  txn_dispatcher #(
    .MAX_DEPENDENCIES (MD),
    .NUM_LANES        (NL)
  ) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_owner),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .exec_valid                      (exec_valid),
    .exec_owner_programID            (exec_owner),
    .exec_done                       (exec_done),
    .m_axis_rel_tvalid               (rel_tvalid),
    .m_axis_rel_tready               (rel_tready),
    .m_axis_rel_owner_programID      (rel_owner),
    .m_axis_rel_read_dependencies    (rel_rd),
    .m_axis_rel_write_dependencies   (rel_wr),
    .lanes_busy                      (lanes_busy),
    .txns_dispatched                 (txns_dispatched),
    .txns_retired                    (txns_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   own;
    logic [MD-1:0] rd;
    logic [MD-1:0] wr;
  } exp_t;

  exp_t sbq[$];
  exp_t lane_m[NL];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_disp = 0;
  int   exp_ret = 0;

  function automatic logic [MD-1:0] bit1(input int b);
    logic [MD-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(input logic [63:0] o,
                              input int rb, input int wb);
    exp_t t;
    t.own = o;
    t.rd  = bit1(rb);
    t.wr  = bit1(wb);
    return t;
  endfunction

  function automatic logic [31:0] sx(input int v);
`ifdef TXN_DISPATCHER_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [MD-1:0] act,
                      input logic [MD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got low64 %0h want low64 %0h",
               nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t t, input int lane);
    int k;
    k = 0;
    while (!s_axis_tready && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got tready 0 want 1");
    end
    s_axis_tvalid = 1'b1;
    s_owner = t.own;
    s_rd    = t.rd;
    s_wr    = t.wr;
    step();
    s_axis_tvalid = 1'b0;
    lane_m[lane] = t;
    exp_disp++;
  endtask

  task automatic stats(input string nm);
    chk({nm, "_disp"}, txns_dispatched, sx(exp_disp));
    chk({nm, "_ret"},  txns_retired,    sx(exp_ret));
  endtask

  task automatic single_txn(input string nm);
    exp_t t;
    t = mk(64'h1, 0, 1);
    send(t, 0);
    chk({nm, "_exec_valid"}, exec_valid, 4'b0001);
    chk({nm, "_exec_owner"}, exec_owner[63:0], 64'h1);
    step();
    step();
    exec_done = 4'b0001;
    sbq.push_back(t);
    exp_ret++;
    step();
    exec_done = '0;
    chk({nm, "_rel_early"}, rel_tvalid, 1'b0);
    chk({nm, "_exec_off"}, exec_valid, 4'b0000);
    step();
    chk({nm, "_rel_valid"}, rel_tvalid, 1'b1);
    step();
    chk({nm, "_rel_gone"}, rel_tvalid, 1'b0);
    stats(nm);
  endtask

  // release monitor: every release handshake pops the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rel_tvalid && rel_tready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rel_unexpected: got owner %0h want none",
                   rel_owner);
        end else begin
          e = sbq.pop_front();
          chk("rel_owner", rel_owner, e.own);
          chkw("rel_rd", rel_rd, e.rd);
          chkw("rel_wr", rel_wr, e.wr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t t;
    s_axis_tvalid = 1'b0;
    s_owner = '0;
    s_rd = '0;
    s_wr = '0;
    exec_done = '0;
    rel_tready = 1'b1;

    // reset state
    #12;
    chk("rst_exec_valid", exec_valid, 4'b0);
    chk("rst_rel_valid", rel_tvalid, 1'b0);
    chk("rst_busy", lanes_busy, 32'd0);
    stats("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_tready", s_axis_tready, 1'b1);

    // single transaction
    single_txn("s1");

    // fill all lanes, fifth waits for a free lane
    for (int i = 0; i < 4; i++)
      send(mk(64'(i + 1), 3 * i + 2, 5 * i + 4), i);
    chk("fill_tready", s_axis_tready, 1'b0);
    chk("fill_busy", lanes_busy, sx(4));
    chk("fill_valid", exec_valid, 4'hF);
    for (int i = 0; i < 4; i++)
      chk("fill_owner", exec_owner[64*i +: 64], 64'(i + 1));
    t = mk(64'h5, 40, 41);
    s_axis_tvalid = 1'b1;
    s_owner = t.own;
    s_rd = t.rd;
    s_wr = t.wr;
    step();
    step();
    step();
    stats("fill_stall");
    exec_done = 4'b1000;
    sbq.push_back(lane_m[3]);
    exp_ret++;
    step();
    exec_done = '0;
    chk("fill_retire_tready", s_axis_tready, 1'b0);
    step();
    chk("fill_freed_tready", s_axis_tready, 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    lane_m[3] = t;
    exp_disp++;
    chk("fill5_valid", exec_valid, 4'hF);
    chk("fill5_owner", exec_owner[255:192], 64'h5);
    stats("fill");

    // simultaneous done on every lane
    exec_done = 4'hF;
    for (int i = 0; i < 4; i++)
      sbq.push_back(lane_m[i]);
    exp_ret += 4;
    step();
    exec_done = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("sim_rel_valid", rel_tvalid, 1'b1);
      chk("sim_rel_owner", rel_owner, lane_m[i].own);
      step();
    end
    chk("sim_rel_gone", rel_tvalid, 1'b0);
    chk("sim_busy", lanes_busy, sx(0));
    stats("sim");

    // backpressure with two lanes retiring
    send(mk(64'h10, 16, 17), 0);
    send(mk(64'h11, 18, 19), 1);
    rel_tready = 1'b0;
    exec_done = 4'b0011;
    sbq.push_back(lane_m[0]);
    sbq.push_back(lane_m[1]);
    exp_ret += 2;
    step();
    exec_done = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rel_tvalid, 1'b1);
      chk("bp_owner", rel_owner, 64'h10);
      chkw("bp_rd", rel_rd, lane_m[0].rd);
      chk("bp_exec", exec_valid, 4'b0);
      chk("bp_busy", lanes_busy, sx(1));
      step();
    end
    rel_tready = 1'b1;
    step();
    chk("bp_second_owner", rel_owner, 64'h11);
    step();
    chk("bp_rel_gone", rel_tvalid, 1'b0);
    stats("bp");

    // reset with three lanes executing and one release pending
    for (int i = 0; i < 4; i++)
      send(mk(64'(32 + i), 50 + i, 60 + i), i);
    rel_tready = 1'b0;
    exec_done = 4'b0001;
    step();
    exec_done = '0;
    step();
    chk("mr_pending", rel_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_exec_valid", exec_valid, 4'b0);
    chkw("mr_exec_owner", MD'(exec_owner), '0);
    chk("mr_rel_valid", rel_tvalid, 1'b0);
    chk("mr_rel_owner", rel_owner, 64'h0);
    chkw("mr_rel_rd", rel_rd, '0);
    chkw("mr_rel_wr", rel_wr, '0);
    chk("mr_busy", lanes_busy, 32'd0);
    exp_disp = 0;
    exp_ret = 0;
    stats("mr");
    sbq.delete();
    rel_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("mr_tready", s_axis_tready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("mr_no_rel", rel_tvalid, 1'b0);
      step();
    end

    // single transaction again from a fresh reset
    single_txn("s2");

    repeat (3) step();
    chk("end_sbq_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
